// File: rtl/alu_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_decode_stage
// Purpose  : RV32I decode stage; turns an instruction into an ALU control word,
//            operand selects and immediate behind one valid/ready register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic [31:0] pc_out
);

    localparam logic [6:0] c_OP_REG  = 7'b0110011;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
    localparam logic [6:0] c_OP_AUI  = 7'b0010111;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_STOR = 7'b0100011;
    localparam logic [6:0] c_OP_BRAN = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;

    localparam logic [1:0] c_A_RS1  = 2'b00;
    localparam logic [1:0] c_A_PC   = 2'b01;
    localparam logic [1:0] c_A_ZERO = 2'b10;
    localparam logic       c_B_RS2  = 1'b0;
    localparam logic       c_B_IMM  = 1'b1;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    logic [3:0]  w_alu_raw;
    logic [1:0]  w_asel_raw;
    logic        w_bsel_raw;
    logic [31:0] w_imm_raw;
    logic        w_wr_raw;
    logic        w_ill;

    logic [3:0]  w_alu;
    logic [1:0]  w_asel;
    logic        w_bsel;
    logic [31:0] w_imm;
    logic        w_wr;

    logic        w_in_ready;
    logic        w_xfer;

    logic        r_valid;
    logic [3:0]  r_alu_ctrl;
    logic [1:0]  r_a_sel;
    logic        r_b_sel;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_illegal;
    logic [31:0] r_pc;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rd     = in_instr[11:7];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Raw per-opcode decode; legality masking is applied afterwards.
    always_comb begin
        w_alu_raw  = c_ALU_ADD;
        w_asel_raw = c_A_RS1;
        w_bsel_raw = c_B_RS2;
        w_imm_raw  = 32'd0;
        w_wr_raw   = 1'b1;
        w_ill      = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                w_alu_raw = {w_funct7[5], w_funct3};
                if ((w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT)) begin
                    w_ill = 1'b1;
                end else if (w_funct7[5] && (w_funct3 != 3'b000) && (w_funct3 != 3'b101)) begin
                    w_ill = 1'b1;
                end
            end
            c_OP_IMM: begin
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_i;
                w_alu_raw  = {1'b0, w_funct3};
                if (w_funct3 == 3'b001) begin
                    if (w_funct7 != c_F7_BASE) begin
                        w_ill = 1'b1;
                    end
                end else if (w_funct3 == 3'b101) begin
                    w_alu_raw = {w_funct7[5], 3'b101};
                    if ((w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT)) begin
                        w_ill = 1'b1;
                    end
                end
            end
            c_OP_LUI: begin
                w_asel_raw = c_A_ZERO;
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_u;
            end
            c_OP_AUI: begin
                w_asel_raw = c_A_PC;
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_u;
            end
            c_OP_LOAD: begin
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_i;
            end
            c_OP_STOR: begin
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_s;
                w_wr_raw   = 1'b0;
            end
            c_OP_BRAN: begin
                w_imm_raw = w_imm_b;
                w_wr_raw  = 1'b0;
                case (w_funct3)
                    3'b000, 3'b001: w_alu_raw = c_ALU_SUB;
                    3'b100, 3'b101: w_alu_raw = c_ALU_SLT;
                    3'b110, 3'b111: w_alu_raw = c_ALU_SLTU;
                    default:        w_ill     = 1'b1;
                endcase
            end
            c_OP_JAL: begin
                w_asel_raw = c_A_PC;
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_j;
            end
            c_OP_JALR: begin
                w_bsel_raw = c_B_IMM;
                w_imm_raw  = w_imm_i;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // Illegal instructions still travel downstream, but with a neutral bundle.
    always_comb begin
        w_alu  = w_alu_raw;
        w_asel = w_asel_raw;
        w_bsel = w_bsel_raw;
        w_imm  = w_imm_raw;
        w_wr   = w_wr_raw && (w_rd != 5'd0);
        if (w_ill) begin
            w_alu  = c_ALU_ADD;
            w_asel = c_A_RS1;
            w_bsel = c_B_RS2;
            w_imm  = 32'd0;
            w_wr   = 1'b0;
        end
    end

    assign w_in_ready = !r_valid || out_ready;
    assign w_xfer     = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_alu_ctrl  <= 4'd0;
            r_a_sel     <= 2'd0;
            r_b_sel     <= 1'b0;
            r_imm       <= 32'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_pc        <= 32'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid     <= 1'b1;
            r_alu_ctrl  <= w_alu;
            r_a_sel     <= w_asel;
            r_b_sel     <= w_bsel;
            r_imm       <= w_imm;
            r_rs1       <= in_instr[19:15];
            r_rs2       <= in_instr[24:20];
            r_rd        <= w_rd;
            r_reg_write <= w_wr;
            r_illegal   <= w_ill;
            r_pc        <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign a_sel     = r_a_sel;
    assign b_sel     = r_b_sel;
    assign imm       = r_imm;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;
    assign pc_out    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_decode_stage
// Purpose  : Scoreboard bench for alu_decode_stage (decode table, stall, flush,
//            asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    localparam int c_N = 18;

    // Hand-decoded reference table.
    logic [31:0] t_instr [c_N] = '{32'h002081B3, 32'h40435293, 32'hFFF00093, 32'h123453B7,
                                   32'h0020C463, 32'h00000000, 32'h4020E1B3, 32'h402081B3,
                                   32'hFFFFF217, 32'hFE20AE23, 32'h01012283, 32'hFF1FF0EF,
                                   32'h00008067, 32'h40009093, 32'h0020A463, 32'h4020D1B3,
                                   32'h00113093, 32'h0020F463};
    logic [3:0]  t_alu   [c_N] = '{4'h0, 4'hD, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0,
                                   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hD, 4'h3, 4'h3};
    logic [1:0]  t_asel  [c_N] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
                                   2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic        t_bsel  [c_N] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_imm   [c_N] = '{32'h0, 32'h404, 32'hFFFFFFFF, 32'h12345000, 32'h8, 32'h0,
                                   32'h0, 32'h0, 32'hFFFFF000, 32'hFFFFFFFC, 32'h10,
                                   32'hFFFFFFF0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8};
    logic        t_rw    [c_N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t_ill   [c_N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_ctrl;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc_out;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    alu_decode_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .imm       (imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .illegal   (illegal),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int idx);
        exp_t e;
        e.alu  = t_alu[idx];
        e.asel = t_asel[idx];
        e.bsel = t_bsel[idx];
        e.imm  = t_imm[idx];
        e.rs1  = t_instr[idx][19:15];
        e.rs2  = t_instr[idx][24:20];
        e.rd   = t_instr[idx][11:7];
        e.rw   = t_rw[idx];
        e.ill  = t_ill[idx];
        e.pc   = 32'h1000 + 32'(idx * 4);
        return e;
    endfunction

    function automatic exp_t cur();
        exp_t e;
        e = '{alu: alu_ctrl, asel: a_sel, bsel: b_sel, imm: imm, rs1: rs1, rs2: rs2,
              rd: rd, rw: reg_write, ill: illegal, pc: pc_out};
        return e;
    endfunction

    task automatic send(input int idx);
        int acc;
        int n;
        acc      = 0;
        n        = 0;
        in_valid = 1'b1;
        in_instr = t_instr[idx];
        in_pc    = 32'h1000 + 32'(idx * 4);
        while (acc == 0 && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                q.push_back(mk(idx));
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (acc == 0) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Output monitor: compare on consume, verify stability while stalled.
    exp_t held;
    bit   stalled = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        exp_t o;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            o = cur();
            if (out_valid && stalled) check("hold_bundle", {31'd0, o == held}, 32'd1);
            if (out_valid && !out_ready) begin
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                stalled = 1'b1;
                held    = o;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", o.pc, 32'hFFFFFFFF);
                end else begin
                    e = q.pop_front();
                    check("pc",   o.pc,  e.pc);
                    check("alu",  {28'd0, o.alu},  {28'd0, e.alu});
                    check("asel", {30'd0, o.asel}, {30'd0, e.asel});
                    check("bsel", {31'd0, o.bsel}, {31'd0, e.bsel});
                    check("imm",  o.imm, e.imm);
                    check("rs1",  {27'd0, o.rs1},  {27'd0, e.rs1});
                    check("rs2",  {27'd0, o.rs2},  {27'd0, e.rs2});
                    check("rd",   {27'd0, o.rd},   {27'd0, e.rd});
                    check("rw",   {31'd0, o.rw},   {31'd0, e.rw});
                    check("ill",  {31'd0, o.ill},  {31'd0, e.ill});
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_imm", imm, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_alu", {28'd0, alu_ctrl}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full decode table, streaming at one per cycle
        out_ready = 1'b1;
        for (int i = 0; i < c_N; i++) send(i);

        // Four back-to-back with a two-cycle stall
        fork
            begin
                for (int i = 0; i < 4; i++) send(i + 7);
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        check("drain1", q.size(), 32'd0);

        // Flush while stalled, with a simultaneous incoming instruction
        out_ready = 1'b0;
        send(4);
        in_valid = 1'b1;
        in_instr = t_instr[5];
        in_pc    = 32'hDEAD0000;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("flush_gone", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset during a stall
        out_ready = 1'b0;
        send(7);
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_alu", {28'd0, alu_ctrl}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16);
        send(17);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("final_drain", q.size(), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
